// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder slice.
// Optional wait states: MEM_WAIT_STATES_EN.
package mem_pkg;

    localparam int ADDR_W          = 32;
    localparam int DEFAULT_DEPTH   = 64;
    localparam int DEFAULT_LATENCY = 2;

`ifdef MEM_WAIT_STATES_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/mem_array.sv
// Word-wide storage: synchronous write, combinational read.
// Contents are never reset.
module mem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: IDLE/WAIT/RESP FSM.
// Wait states are compiled in with MEM_WAIT_STATES_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              bad;
    logic              wr_en;
    logic [31:0]       mem_rd;
    logic              accept;

    assign accept = (state_q == IDLE) && req;

`ifdef MEM_WAIT_STATES_EN
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
`ifdef MEM_WAIT_STATES_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MEM_WAIT_STATES_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef MEM_WAIT_STATES_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
`ifdef MEM_WAIT_STATES_EN
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef MEM_WAIT_STATES_EN
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requester may drop its inputs after the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    assign bad = (addr_q[1:0] != 2'b00)
              || (addr_q[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));

    always_comb begin
        ready = (state_q == RESP);
        busy  = (state_q != IDLE);
        err   = ready && bad;
        wr_en = ready && we_q && !bad;
        rdata = (ready && !we_q && !bad) ? mem_rd : 32'd0;
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .idx_i   (addr_q[IDX_W+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rd)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array model.
// Build with or without MEM_WAIT_STATES_EN.
module tb_mem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;
`ifdef MEM_WAIT_STATES_EN
    localparam int EXP_LAT = LATENCY + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] model [DEPTH];

    mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic access(input logic w, input logic [31:0] a,
                          input logic [31:0] d);
        int n;
        logic e;
        logic [31:0] exp_rd;
        e = is_bad(a);
        exp_rd = (!w && !e) ? model[a / 4] : 32'd0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = $urandom; addr = $urandom; wdata = $urandom;
        n = 1;
        while (!ready && n < 16) begin
            check("wait_busy", {31'd0, busy}, 32'd1);
            check("wait_err", {31'd0, err}, 32'd0);
            check("wait_rdata", rdata, 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(EXP_LAT));
        check("resp_err", {31'd0, err}, {31'd0, e});
        check("resp_rdata", rdata, exp_rd);
        @(negedge clk);
        check("ready_pulse", {31'd0, ready}, 32'd0);
        check("after_rdata", rdata, 32'd0);
        if (w && !e) model[a / 4] = d;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (k < 8) return (32'($urandom_range(0, DEPTH - 1)) << 2)
                          + 32'($urandom_range(1, 3));
        return 32'($urandom_range(DEPTH, 4000)) << 2;
    endfunction

    initial begin
        int last;
        bit saw_idle;
        logic [31:0] ha;

        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i) << 2, $urandom);

        access(1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 32'h10, 32'h0);
        check("rd_deadbeef", model[4], 32'hDEADBEEF);

        access(1'b1, 32'h10, 32'hAA);
        access(1'b1, 32'h13, 32'h1);
        access(1'b0, 32'h10, 32'h0);

        access(1'b0, 32'h100, 32'h0);

        access(1'b1, 32'h20, 32'h1234_5678);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_ready", {31'd0, ready}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_rdata", rdata, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 32'h20, 32'h0);

        ha = 32'($urandom_range(0, DEPTH - 1)) << 2;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = ha;
        last = -1;
        saw_idle = 1'b0;
        for (int i = 0; i < 5 * (EXP_LAT + 1); i++) begin
            @(negedge clk);
            if (ready) begin
                check("hold_rdata", rdata, model[ha / 4]);
                if (last >= 0) begin
                    check("hold_period", 32'(i - last), 32'(EXP_LAT + 1));
                    check("hold_idle", {31'd0, saw_idle}, 32'd1);
                end
                last = i;
                saw_idle = 1'b0;
            end else if (!busy) begin
                saw_idle = 1'b1;
            end
        end
        check("hold_seen", {31'd0, last >= 0}, 32'd1);
        req = 1'b0;
        for (int i = 0; i < 16 && busy; i++) @(negedge clk);
        check("hold_drain", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            access(1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
        for (int i = 0; i < 8; i++) access(1'b0, 32'(i) << 2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
